// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller for a 5-stage core: EX/MEM/WB bypass selection,
// load-use bubbles, data-memory wait freezes, branch/trap flushes and stall counting.
module id_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rd_we_i,
  input  logic             id_is_load_i,
  input  logic [31:0]      ex_result_i,
  input  logic [31:0]      mem_result_i,
  input  logic [31:0]      wb_data_i,
  input  logic             mem_wait_i,
  input  logic             ex_branch_taken_i,
  input  logic             trap_i,
  output logic             is_fwd_a_o,
  output logic             is_fwd_b_o,
  output logic [31:0]      dat_fwd_a_o,
  output logic [31:0]      dat_fwd_b_o,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             bubble_ex_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  state_e state_q;

  logic             ex_v_q,  ex_v_d,  ex_we_q,  ex_we_d,  ex_ld_q, ex_ld_d;
  logic             mem_v_q, mem_v_d, mem_we_q, mem_we_d;
  logic             wb_v_q,  wb_v_d,  wb_we_q,  wb_we_d;
  logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_wr_s, mem_wr_s, wb_wr_s;
  logic use_a_s, use_b_s;
  logic lu_hz_s, freeze_s;

  assign ex_wr_s  = ex_v_q  & ex_we_q  & (ex_rd_q  != 5'd0);
  assign mem_wr_s = mem_v_q & mem_we_q & (mem_rd_q != 5'd0);
  assign wb_wr_s  = wb_v_q  & wb_we_q  & (wb_rd_q  != 5'd0);
  assign use_a_s  = id_uses_rs1_i & (id_rs1_i != 5'd0);
  assign use_b_s  = id_uses_rs2_i & (id_rs2_i != 5'd0);
  assign lu_hz_s  = id_valid_i & ex_wr_s & ex_ld_q &
                    ((use_a_s & (ex_rd_q == id_rs1_i)) | (use_b_s & (ex_rd_q == id_rs2_i)));
  assign freeze_s = mem_wait_i & ~trap_i;
  assign stall_cnt_o = stall_cnt_q;

  // Operand A bypass: youngest producer wins; a load in EX has no data yet
  always_comb begin
    is_fwd_a_o  = 1'b0;
    dat_fwd_a_o = 32'd0;
    if (use_a_s && ex_wr_s && !ex_ld_q && (ex_rd_q == id_rs1_i)) begin
      is_fwd_a_o  = 1'b1;
      dat_fwd_a_o = ex_result_i;
    end else if (use_a_s && mem_wr_s && (mem_rd_q == id_rs1_i)) begin
      is_fwd_a_o  = 1'b1;
      dat_fwd_a_o = mem_result_i;
    end else if (use_a_s && wb_wr_s && (wb_rd_q == id_rs1_i)) begin
      is_fwd_a_o  = 1'b1;
      dat_fwd_a_o = wb_data_i;
    end else begin
      is_fwd_a_o  = 1'b0;
      dat_fwd_a_o = 32'd0;
    end
  end

  // Operand B bypass, same priority as operand A
  always_comb begin
    is_fwd_b_o  = 1'b0;
    dat_fwd_b_o = 32'd0;
    if (use_b_s && ex_wr_s && !ex_ld_q && (ex_rd_q == id_rs2_i)) begin
      is_fwd_b_o  = 1'b1;
      dat_fwd_b_o = ex_result_i;
    end else if (use_b_s && mem_wr_s && (mem_rd_q == id_rs2_i)) begin
      is_fwd_b_o  = 1'b1;
      dat_fwd_b_o = mem_result_i;
    end else if (use_b_s && wb_wr_s && (wb_rd_q == id_rs2_i)) begin
      is_fwd_b_o  = 1'b1;
      dat_fwd_b_o = wb_data_i;
    end else begin
      is_fwd_b_o  = 1'b0;
      dat_fwd_b_o = 32'd0;
    end
  end

  // Pipeline control, priority trap > mem wait > branch > load-use; quiet in reset
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    bubble_ex_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    if (rst_i) begin
      stall_if_o = 1'b0;
    end else if (trap_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (mem_wait_i) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (lu_hz_s) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      bubble_ex_o = 1'b1;
    end else begin
      stall_if_o = 1'b0;
    end
  end

  // Next-state of the stage trackers and the stall counter
  always_comb begin
    ex_v_d   = ex_v_q;   ex_rd_d  = ex_rd_q;  ex_we_d  = ex_we_q;  ex_ld_d = ex_ld_q;
    mem_v_d  = mem_v_q;  mem_rd_d = mem_rd_q; mem_we_d = mem_we_q;
    wb_v_d   = wb_v_q;   wb_rd_d  = wb_rd_q;  wb_we_d  = wb_we_q;
    if (stall_if_o) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (trap_i) begin
      ex_v_d  = 1'b0;
      mem_v_d = 1'b0;
      wb_v_d  = 1'b0;
    end else if (freeze_s) begin
      wb_v_d = 1'b0;
    end else begin
      wb_v_d  = mem_v_q; wb_rd_d  = mem_rd_q; wb_we_d  = mem_we_q;
      mem_v_d = ex_v_q;  mem_rd_d = ex_rd_q;  mem_we_d = ex_we_q;
      if (id_valid_i && !lu_hz_s && !ex_branch_taken_i) begin
        ex_v_d  = 1'b1;
        ex_rd_d = id_rd_i;
        ex_we_d = id_rd_we_i;
        ex_ld_d = id_is_load_i;
      end else begin
        ex_v_d = 1'b0;
      end
    end
  end

  // Tracker and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_v_q  <= 1'b0; ex_rd_q  <= 5'd0; ex_we_q  <= 1'b0; ex_ld_q <= 1'b0;
      mem_v_q <= 1'b0; mem_rd_q <= 5'd0; mem_we_q <= 1'b0;
      wb_v_q  <= 1'b0; wb_rd_q  <= 5'd0; wb_we_q  <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_v_q  <= ex_v_d;  ex_rd_q  <= ex_rd_d;  ex_we_q  <= ex_we_d;  ex_ld_q <= ex_ld_d;
      mem_v_q <= mem_v_d; mem_rd_q <= mem_rd_d; mem_we_q <= mem_we_d;
      wb_v_q  <= wb_v_d;  wb_rd_q  <= wb_rd_d;  wb_we_q  <= wb_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory-wait FSM; a trap always drops back to RUN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!trap_i && mem_wait_i && mem_v_q) state_q <= ST_MEM_WAIT;
          else                                  state_q <= ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (trap_i || !mem_wait_i) state_q <= ST_RUN;
          else                       state_q <= ST_MEM_WAIT;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline controller for the instruction-decode stage. It tracks destination registers of instructions in EX, MEM and WB, and drives the ID stage forwarding inputs (`is_fwd_a_i`/`is_fwd_b_i`, `dat_fwd_a_i`/`dat_fwd_b_i`). It generates load-use bubbles, memory-wait freezes and branch/trap flushes for the 5-stage core. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i  in  5  rs1 of ID instruction
- id_rs2_i  in  5  rs2 of ID instruction
- id_uses_rs1_i  in  1  ID instruction reads rs1 (sel_dat_a = register)
- id_uses_rs2_i  in  1  ID instruction reads rs2 (sel_dat_b = register, or store/branch)
- id_rd_i  in  5  rd of ID instruction
- id_rd_we_i  in  1  ID instruction writes rd
- id_is_load_i  in  1  ID instruction is a load
- ex_result_i  in  32  ALU result of the instruction in EX
- mem_result_i  in  32  result of MEM instruction (load data when load)
- wb_data_i  in  32  register-file write data in WB
- mem_wait_i  in  1  data memory has not acknowledged the MEM access
- ex_branch_taken_i  in  1  taken branch/jump resolved in EX
- trap_i  in  1  exception/interrupt redirect
- is_fwd_a_o  out  1  forward to operand A
- is_fwd_b_o  out  1  forward to operand B
- dat_fwd_a_o  out  32  forwarded rs1 value
- dat_fwd_b_o  out  32  forwarded rs2 value
- stall_if_o  out  1  hold PC and IF/ID
- stall_id_o  out  1  hold ID/EX inputs
- bubble_ex_o  out  1  inject NOP into EX
- flush_id_o  out  1  kill IF/ID content
- flush_ex_o  out  1  kill ID/EX content
- stall_cnt_o  out  CNT_W  cycles with stall_if_o=1

## Operation
- Tracking registers per stage S∈{EX,MEM,WB}: valid, rd, rd_we, is_load. A stage counts as a "writer" when valid=1, rd_we=1 and rd≠0.
- Forwarding for rsX (X=1,2) when id_uses_rsX_i=1 and rsX≠0, in priority order:
  - EX writer, not a load, with rd==rsX: ex_result_i
  - else MEM writer with rd==rsX: mem_result_i
  - else WB writer with rd==rsX: wb_data_i
  - else is_fwd=0 and dat_fwd=0
- Forward outputs are combinational from the tracking registers and the inputs.
- Load-use: an EX writer with is_load=1 and rd matching a used rsX (≠0), while id_valid_i=1, raises lu_hz. lu_hz drives stall_if_o=1, stall_id_o=1 and bubble_ex_o=1 for one cycle; forwarding from MEM then applies.
- FSM states RUN and MEM_WAIT:
  - RUN→MEM_WAIT when mem_wait_i=1 and the MEM stage is valid.
  - MEM_WAIT→RUN on the first cycle with mem_wait_i=0.
  - While mem_wait_i=1 (either state): stall_if_o=1, stall_id_o=1 and bubble_ex_o=0. EX and MEM tracking stay frozen, and WB tracking becomes invalid (the WB instruction retires).
- Tracking advance when not frozen:
  - WB←MEM, MEM←EX.
  - EX←ID fields if id_valid_i=1 and neither lu_hz nor flush is active; otherwise EX←invalid.
- ex_branch_taken_i=1 (and not frozen): flush_id_o=1 and flush_ex_o=1 for that cycle, and EX←invalid on the next edge. This takes priority over lu_hz, so no stall or bubble is raised.
- trap_i=1: flush_id_o=1 and flush_ex_o=1. EX, MEM and WB tracking clear to invalid on the next edge and the FSM returns to RUN. trap_i overrides mem_wait_i and all other conditions.
- stall_cnt_o increments by 1 on every edge where stall_if_o=1 and wraps modulo 2^CNT_W.

## Timing
- Reset (async, immediate):
  - all tracking valid=0, FSM=RUN, stall_cnt_o=0
  - all 1-bit outputs 0, dat_fwd_*_o=0
- Deasserting rst_i takes effect at the next rising clk_i.
- Control and forward outputs are combinational in the same cycle; there is no added latency.
- Tracking registers and the counter update on the rising edge.
- A load-use stall costs exactly 1 cycle. A memory wait costs one stall per cycle of mem_wait_i=1. A branch costs 2 killed slots (IF/ID and ID/EX).
- Simultaneous events, highest priority first: trap_i > mem_wait_i > ex_branch_taken_i > lu_hz.
- Reset asserted mid-MEM_WAIT: outputs drop to 0 immediately and the FSM is in RUN after release.

## Test plan
- Back-to-back ALU ops, add x5 followed by sub x6,x5,x5 with ex_result_i=0x1234: is_fwd_a_o=is_fwd_b_o=1 and dat_fwd_a_o=dat_fwd_b_o=0x1234 in the same cycle; no stall.
- Writes to x0, rd=x0 in EX/MEM/WB with rs1=x0: is_fwd_a_o=0 and dat_fwd_a_o=0.
- lw x7 then add x8,x7,x1: one cycle of stall_if_o=stall_id_o=bubble_ex_o=1. Next cycle dat_fwd_a_o=mem_result_i (0xCAFEBABE) and stall_cnt_o=1.
- mem_wait_i high for 3 cycles with a load in MEM: FSM in MEM_WAIT, stall_if_o=1 for 3 cycles, stall_cnt_o advances by 3, WB invalid after the first edge. Release returns to RUN.
- ex_branch_taken_i in the same cycle as a load-use hazard: flush_id_o=flush_ex_o=1, stall_if_o=0, bubble_ex_o=0.
- trap_i during MEM_WAIT: flush_id_o=flush_ex_o=1, stall deasserted. Next cycle FSM=RUN and all tracking invalid, so no forwarding occurs. Async reset mid-run clears stall_cnt_o to 0 immediately.
